// File: rtl/secure_pipe_arbiter.sv
// Round-robin owner of one shared sensitive-data pipeline. Every change of ownership is
// separated by PIPE_DEPTH zero words, which drain the last owner's results and scrub each stage.
module secure_pipe_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 128,
  parameter int PIPE_DEPTH   = 3,
  parameter int BURST_MAX    = 8,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       dp_enable,
  output logic [DATA_W-1:0]          dp_data_in,
  input  logic [DATA_W-1:0]          dp_data_out,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [DATA_W-1:0]          resp_data,
  output logic                       scrub_active,
  output logic                       busy
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int BC_W = $clog2(BURST_MAX + 1);
  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int SC_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, SCRUB} state_t;

  state_t                             state, state_nxt;
  logic [ID_W-1:0]                    owner, rr_ptr, arb_id, cand;
  logic                               arb_hit, accept, burst_end, timeout;
  logic [BC_W-1:0]                    beat_cnt;
  logic [TO_W-1:0]                    to_cnt;
  logic [SC_W-1:0]                    scrub_cnt;
  logic [NUM_REQ-1:0][DATA_W-1:0]     req_words;
  logic [PIPE_DEPTH-1:0]              tok_vld, vld_pipe;
  logic [PIPE_DEPTH-1:0][ID_W-1:0]    tok_id, id_pipe;
  logic                               en_q;

  assign req_words = req_data;

  // Reverse scan so the last hit is the nearest requester at or after rr_ptr.
  always_comb begin
    arb_hit = 1'b0;
    arb_id  = rr_ptr;
    cand    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req_valid[cand]) begin
        arb_hit = 1'b1;
        arb_id  = cand;
      end
    end
  end

  assign accept    = rst_n && (state == GRANT) && req_valid[owner];
  assign burst_end = accept && (req_last[owner] || (beat_cnt == BC_W'(BURST_MAX - 1)));
  assign timeout   = (state == GRANT) && !req_valid[owner] && (to_cnt == TO_W'(IDLE_TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arb_hit) state_nxt = GRANT;
      GRANT:   if (burst_end || timeout) state_nxt = SCRUB;
      SCRUB:   if (scrub_cnt == SC_W'(PIPE_DEPTH - 1)) state_nxt = IDLE;
      default: state_nxt = SCRUB;
    endcase
  end

  // Datapath controls are gated by rst_n so they fall the instant reset asserts.
  always_comb begin
    req_ready  = '0;
    dp_enable  = 1'b0;
    dp_data_in = '0;
    if (rst_n) begin
      unique case (state)
        GRANT: begin
          req_ready[owner] = 1'b1;
          if (accept) begin
            dp_enable  = 1'b1;
            dp_data_in = req_words[owner];
          end
        end
        SCRUB:   dp_enable = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCRUB;
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      to_cnt    <= '0;
      scrub_cnt <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: if (arb_hit) begin
          owner    <= arb_id;
          beat_cnt <= '0;
          to_cnt   <= '0;
        end
        GRANT: begin
          if (accept && beat_cnt != BC_W'(BURST_MAX)) beat_cnt <= beat_cnt + 1'b1;
          if (req_valid[owner])                       to_cnt   <= '0;
          else if (to_cnt != TO_W'(IDLE_TIMEOUT))     to_cnt   <= to_cnt + 1'b1;
          if (state_nxt == SCRUB) begin
            rr_ptr    <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
            scrub_cnt <= '0;
          end
        end
        SCRUB: scrub_cnt <= (scrub_cnt == SC_W'(PIPE_DEPTH - 1)) ? '0 : scrub_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Token shadow of the datapath: stage 0 takes the accepted-beat flag and its owner.
  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_tok
    if (k == 0) begin : g_head
      assign vld_pipe[k] = accept;
      assign id_pipe[k]  = owner;
    end else begin : g_body
      assign vld_pipe[k] = tok_vld[k-1];
      assign id_pipe[k]  = tok_id[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_vld <= '0;
      tok_id  <= '0;
      en_q    <= 1'b0;
    end else begin
      en_q <= dp_enable;
      if (dp_enable) begin
        tok_vld <= vld_pipe;
        tok_id  <= id_pipe;
      end
    end
  end

  // A token in the last stage is reported only in the cycle right after the enable that moved it there.
  assign resp_valid   = en_q && tok_vld[PIPE_DEPTH-1];
  assign resp_id      = resp_valid ? tok_id[PIPE_DEPTH-1] : '0;
  assign resp_data    = resp_valid ? dp_data_out : '0;
  assign scrub_active = rst_n && (state == SCRUB);
  assign busy         = rst_n && (state != IDLE);

endmodule

// File: tb/tb_secure_pipe_arbiter.sv
// Scoreboard bench for secure_pipe_arbiter: per-requester beat queues drive the ports,
// accepted beats push expected results, and a monitor checks every cycle.
module tb_secure_pipe_arbiter;
  localparam int NR = 4;
  localparam int DW = 128;
  localparam logic [DW-1:0] MASK = {16{8'hA5}};

  typedef struct packed { logic [DW-1:0] data; logic last; logic [7:0] gap; } beat_t;
  typedef struct packed { logic [1:0] id; logic [DW-1:0] data; } resp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid, req_last, req_ready;
  logic [NR*DW-1:0] req_data;
  logic             dp_enable, resp_valid, scrub_active, busy;
  logic [DW-1:0]    dp_data_in, dp_data_out, resp_data;
  logic [1:0]       resp_id;
  logic [DW-1:0]    st0, st1, st2;

  beat_t src_q [NR][$];
  resp_t exp_resp [$];
  int    exp_grant [$];
  int    checks, errors;

  always #5 clk = ~clk;

  secure_pipe_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .dp_enable(dp_enable), .dp_data_in(dp_data_in), .dp_data_out(dp_data_out),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .scrub_active(scrub_active), .busy(busy)
  );

  // Datapath stand-in: three enable-advanced stages, output word XOR A5 pattern.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st0 <= '0; st1 <= '0; st2 <= '0;
    end else if (dp_enable) begin
      st0 <= dp_data_in; st1 <= st0; st2 <= st1;
    end
  end
  assign dp_data_out = st2 ^ MASK;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_beat(input int id, input logic [7:0] pat, input bit last, input int gap);
    beat_t b;
    b.data = {16{pat}};
    b.last = last;
    b.gap  = 8'(gap);
    src_q[id].push_back(b);
  endtask

  task automatic wait_accept(input int id, input int limit, input string name);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (req_valid[id] && req_ready[id]) return;
    end
    checks++; errors++;
    $display("FAIL %s: no acceptance within %0d cycles", name, limit);
  endtask

  task automatic wait_drained(input int limit, input string name);
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      if (!busy && exp_resp.size() == 0 && src_q[0].size() == 0 && src_q[1].size() == 0 &&
          src_q[2].size() == 0 && src_q[3].size() == 0) return;
    end
    checks++; errors++;
    $display("FAIL %s: not drained after %0d cycles", name, limit);
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_req_ready"}, req_ready, 0);
    chk({name, "_dp_enable"}, dp_enable, 0);
    chk({name, "_dp_data_in"}, dp_data_in, 0);
    chk({name, "_resp_valid"}, resp_valid, 0);
    chk({name, "_resp_id"}, resp_id, 0);
    chk({name, "_resp_data"}, resp_data, 0);
  endtask

  // Requester driver: presents queue heads, honours per-beat gaps, records accepted beats.
  initial begin
    logic [NR-1:0] acc;
    int            gap_left [NR];
    bit            loaded [NR];
    resp_t         r;
    req_valid = '0; req_last = '0; req_data = '0;
    for (int i = 0; i < NR; i++) begin gap_left[i] = 0; loaded[i] = 1'b0; end
    forever begin
      @(negedge clk);
      acc = rst_n ? (req_valid & req_ready) : '0;
      for (int i = 0; i < NR; i++) if (acc[i]) begin
        r.id   = 2'(i);
        r.data = req_data[i*DW +: DW] ^ MASK;
        exp_resp.push_back(r);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && src_q[i].size() > 0) begin
          void'(src_q[i].pop_front());
          loaded[i] = 1'b0;
        end else if (loaded[i] && gap_left[i] > 0) gap_left[i]--;
        if (src_q[i].size() == 0) loaded[i] = 1'b0;
        if (!loaded[i] && src_q[i].size() > 0) begin
          loaded[i]   = 1'b1;
          gap_left[i] = int'(src_q[i][0].gap);
        end
        if (loaded[i] && gap_left[i] == 0) begin
          req_valid[i]          = 1'b1;
          req_last[i]           = src_q[i][0].last;
          req_data[i*DW +: DW]  = src_q[i][0].data;
        end else begin
          req_valid[i]          = 1'b0;
          req_last[i]           = 1'b0;
          req_data[i*DW +: DW]  = '0;
        end
      end
    end
  end

  // Monitor: response scoreboard, grant order, scrub length and datapath-drive rules.
  initial begin
    logic [NR-1:0] prev_ready, exp_ready;
    logic [DW-1:0] exp_din;
    int            run;
    bit            scrub_ok;
    resp_t         r;
    prev_ready = '0; run = 0; scrub_ok = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ready = '0; run = 0; scrub_ok = 1'b0;
      end else begin
        if (resp_valid) begin
          if (exp_resp.size() == 0) begin
            checks++; errors++;
            $display("FAIL resp_unexpected: got id %0d data %0h, none owed", resp_id, resp_data);
          end else begin
            r = exp_resp.pop_front();
            chk("resp_id", resp_id, r.id);
            chk("resp_data", resp_data, r.data);
          end
        end else chk("resp_data_idle", resp_data, 0);
        chk("ready_onehot", $countones(req_ready) <= 1, 1);
        exp_din = '0;
        for (int i = 0; i < NR; i++) if (req_valid[i] && req_ready[i]) exp_din = req_data[i*DW +: DW];
        chk("dp_enable", dp_enable, scrub_active || (|(req_valid & req_ready)));
        chk("dp_data_in", dp_data_in, exp_din);
        if (scrub_active) run++;
        else if (run > 0) begin
          chk("scrub_len", run, 3);
          scrub_ok = 1'b1;
          run = 0;
        end
        if (req_ready != 0 && prev_ready == 0) begin
          chk("scrub_before_grant", scrub_ok, 1);
          scrub_ok = 1'b0;
          if (exp_grant.size() == 0) begin
            checks++; errors++;
            $display("FAIL grant_unexpected: got ready %b, no grant expected", req_ready);
          end else begin
            exp_ready = 4'b0001 << exp_grant.pop_front();
            chk("grant_owner", req_ready, exp_ready);
          end
        end
        prev_ready = req_ready;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");

    // Release with req0 pending: scrub x3, one IDLE, then grant; two results during scrub.
    add_beat(0, 8'h11, 0, 0);
    add_beat(0, 8'h22, 1, 0);
    exp_grant.push_back(0);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t1_scrub", {scrub_active, dp_enable}, 2'b11);
      chk("t1_scrub_zero", dp_data_in, 0);
    end
    @(negedge clk);
    chk("t1_idle", {busy, req_ready}, 0);
    @(negedge clk);
    chk("t1_grant", req_ready, 4'b0001);
    wait_drained(60, "t2_drain");

    // Req2 streams 10 unterminated beats, req3 waits: 8 beats, req3, then req2 again.
    for (int k = 0; k < 10; k++) add_beat(2, 8'h30 + 8'(k), 0, 0);
    add_beat(3, 8'h3F, 1, 0);
    exp_grant.push_back(2); exp_grant.push_back(3); exp_grant.push_back(2);
    wait_accept(2, 20, "t4_grant");
    n = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!req_ready[2]) break;
      if (req_valid[2]) n++;
    end
    chk("t4_burst_len", n, 8);
    wait_drained(200, "t4_drain");

    // Owner stalls mid-burst: revoked after 16 low cycles, pipe left holding only zeros.
    add_beat(1, 8'h5A, 0, 0);
    add_beat(1, 8'hC3, 1, 20);
    exp_grant.push_back(1); exp_grant.push_back(1);
    wait_accept(1, 20, "t5_grant");
    n = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (req_ready == 4'b0010 && !req_valid[1]) n++;
      else break;
    end
    chk("t5_timeout", n, 16);
    chk("t5_scrub", scrub_active, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (!scrub_active) break;
    end
    chk("t5_zeroed", st0 | st1 | st2, 0);
    wait_drained(100, "t5_drain");

    // Reset in the middle of a req3 burst.
    for (int k = 0; k < 6; k++) add_beat(3, 8'h60 + 8'(k), k == 5, 0);
    exp_grant.push_back(3);
    wait_accept(3, 20, "t6_grant");
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_outputs_zero("t6_async");
    src_q[3].delete();
    exp_resp.delete();
    repeat (3) @(posedge clk);

    // All four requesters, single-beat bursts: order 0,1,2,3,0 from a fresh pointer.
    add_beat(0, 8'hE0, 1, 0);
    add_beat(0, 8'hE4, 1, 0);
    add_beat(1, 8'hE1, 1, 0);
    add_beat(2, 8'hE2, 1, 0);
    add_beat(3, 8'hE3, 1, 0);
    for (int k = 0; k < 5; k++) exp_grant.push_back(k % 4);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_scrub_first", {scrub_active, req_ready}, 5'b10000);
    wait_drained(200, "t3_drain");

    chk("grants_outstanding", exp_grant.size(), 0);
    chk("resps_outstanding", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
